// File: rtl/patterngen_pkg.sv
// patterngen_pkg: mode and state encodings shared by the pattern engine files
package patterngen_pkg;
  typedef enum logic [1:0] {MODE_SOLID, MODE_GRAD, MODE_CHECK, MODE_IMAGE} mode_e;
  typedef enum logic [1:0] {IDLE, FILL, SWAP} state_e;
  localparam int CHECK_CELL_LOG = 2;
endpackage

// File: rtl/pattern_engine_if.sv
// pattern_engine_if: sprite ROM read port and frame-buffer write port
interface pattern_engine_if #(
  parameter int COLS = 32,
  parameter int ROWS = 16,
  parameter int BPC = 8
);
  localparam int AW = $clog2(COLS * ROWS);
  logic [AW-1:0] img_addr;
  logic [2:0] img_frame;
  logic [3*BPC-1:0] img_rgb;
  logic [AW-1:0] wr_addr;
  logic [3*BPC-1:0] wr_rgb;
  logic wr_valid;
  logic wr_ready;
  modport master(output img_addr, img_frame, wr_addr, wr_rgb, wr_valid, input img_rgb, wr_ready);
  modport slave(input img_addr, img_frame, wr_addr, wr_rgb, wr_valid, output img_rgb, wr_ready);
endinterface

// File: rtl/pattern_pixel.sv
// pattern_pixel: combinational pixel colour for one panel coordinate
module pattern_pixel
  import patterngen_pkg::*;
#(
  parameter int CW = 5,
  parameter int RW = 4,
  parameter int BPC = 8
) (
  input  mode_e            mode_i,
  input  logic [CW-1:0]    col_i,
  input  logic [RW-1:0]    row_i,
  input  logic [BPC-1:0]   fc_i,
  input  logic [3*BPC-1:0] color_i,
  input  logic [3*BPC-1:0] img_rgb_i,
  output logic [3*BPC-1:0] rgb_o
);
  logic [BPC-1:0] r;
  logic [BPC-1:0] g;
  logic hit;
  assign r = BPC'(col_i) << (BPC - CW);
  assign g = BPC'(row_i) << (BPC - RW);
  assign hit = col_i[CHECK_CELL_LOG] ^ row_i[CHECK_CELL_LOG] ^ fc_i[4];
  assign rgb_o = (mode_i == MODE_SOLID) ? color_i :
                 (mode_i == MODE_GRAD)  ? {r, g, fc_i} :
                 (mode_i == MODE_CHECK) ? (hit ? color_i : '0) : img_rgb_i;
endmodule

// File: rtl/pattern_engine.sv
// pattern_engine: fills a panel frame buffer with a selectable pattern on every frame tick
module pattern_engine
  import patterngen_pkg::*;
#(
  parameter int COLS = 32,
  parameter int ROWS = 16,
  parameter int BPC = 8,
  parameter int SCROLL_SHIFT = 2,
  parameter int ANIM_SHIFT = 10,
  parameter int FC_W = 13
) (
  input  logic             pixclk,
  input  logic             reset,
  input  logic             frame_tick,
  input  logic [1:0]       mode,
  input  logic [3*BPC-1:0] color,
  pattern_engine_if.master bus,
  output logic             display,
  output logic             frame_done,
  output logic             overrun
);
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam int AW = CW + RW;
  localparam logic [AW-1:0] LAST = AW'(COLS * ROWS - 1);
  state_e state_q, state_d;
  mode_e mode_q, mode_d;
  logic [3*BPC-1:0] color_q, color_d, rgb_q, rgb_d, px;
  logic [FC_W-1:0] fc_q, fc_d;
  logic [AW-1:0] cnt_q, cnt_d, waddr_q, waddr_d;
  logic s0v_q, s0v_d, valid_q, valid_d, fresh_q, fresh_d;
  logic disp_q, disp_d, done_q, done_d, ovr_q, ovr_d;
  logic load, last_acc, fill;
  logic [CW-1:0] col, scroll;
  logic [RW-1:0] row;
  assign col = cnt_q[CW-1:0];
  assign row = cnt_q[AW-1:CW];
  assign scroll = fc_q[SCROLL_SHIFT +: CW];
  assign fill = (state_q == FILL);
  assign load = s0v_q & (~valid_q | bus.wr_ready);
  assign last_acc = valid_q & bus.wr_ready & (waddr_q == LAST);
  pattern_pixel #(.CW(CW), .RW(RW), .BPC(BPC)) u_pixel (
    .mode_i(mode_q),
    .col_i(col),
    .row_i(row),
    .fc_i(fc_q[BPC-1:0]),
    .color_i(color_q),
    .img_rgb_i(bus.img_rgb),
    .rgb_o(px)
  );
  always_comb begin
    state_d = state_q;
    mode_d = mode_q;
    color_d = color_q;
    cnt_d = load ? cnt_q + 1'b1 : cnt_q;
    s0v_d = s0v_q & ~(load & (cnt_q == LAST));
    valid_d = load | (valid_q & ~bus.wr_ready);
    waddr_d = load ? cnt_q : waddr_q;
    fresh_d = load & (mode_q == MODE_IMAGE);
    rgb_d = load ? px : fresh_q ? bus.img_rgb : rgb_q;
    disp_d = disp_q ^ last_acc;
    done_d = last_acc;
    fc_d = fc_q + FC_W'(last_acc);
    ovr_d = frame_tick & (state_q != IDLE);
    case (state_q)
      IDLE: if (frame_tick) begin
        state_d = FILL;
        mode_d = mode_e'(mode);
        color_d = color;
        cnt_d = '0;
        s0v_d = 1'b1;
      end
      FILL: if (last_acc) state_d = SWAP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge pixclk) begin
    if (!reset) begin
      state_q <= IDLE;
      mode_q <= MODE_SOLID;
      color_q <= '0;
      rgb_q <= '0;
      fc_q <= '0;
      cnt_q <= '0;
      waddr_q <= '0;
      s0v_q <= 1'b0;
      valid_q <= 1'b0;
      fresh_q <= 1'b0;
      disp_q <= 1'b0;
      done_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q <= mode_d;
      color_q <= color_d;
      rgb_q <= rgb_d;
      fc_q <= fc_d;
      cnt_q <= cnt_d;
      waddr_q <= waddr_d;
      s0v_q <= s0v_d;
      valid_q <= valid_d;
      fresh_q <= fresh_d;
      disp_q <= disp_d;
      done_q <= done_d;
      ovr_q <= ovr_d;
    end
  end
  // In image mode the ROM's own output register holds S1 data; it is captured locally only once a stall begins.
  assign bus.wr_rgb = fresh_q ? bus.img_rgb : rgb_q;
  assign bus.wr_valid = valid_q;
  assign bus.wr_addr = waddr_q;
  assign bus.img_addr = fill ? {row, col - scroll} : '0;
  assign bus.img_frame = fill ? fc_q[ANIM_SHIFT +: 3] : 3'd0;
  assign display = disp_q;
  assign frame_done = done_q;
  assign overrun = ovr_q;
endmodule

// File: tb/tb_pattern_engine.sv
// tb_pattern_engine: directed checks of frame fill, patterns, handshake and control pulses
module tb_pattern_engine;
  localparam int COLS = 32;
  localparam int ROWS = 16;
  localparam int BPC = 8;
  localparam int N = COLS * ROWS;
  logic pixclk = 1'b0;
  logic reset = 1'b0;
  logic frame_tick = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [23:0] color = 24'h0;
  logic display, frame_done, overrun;
  logic [23:0] rom_q = 24'h0;
  int tests = 0;
  int fails = 0;
  int fc_exp = 0;
  logic disp_exp = 1'b0;
  int wr_n, t_first, t_last, done_n, done_k, ovr_n, ovr_k, stall_bad;
  logic disp_done;
  logic [8:0] ia2;
  logic [2:0] if2;
  logic [8:0] got_addr [N];
  logic [23:0] got_rgb [N];

  pattern_engine_if #(.COLS(COLS), .ROWS(ROWS), .BPC(BPC)) bus();

  pattern_engine #(.COLS(COLS), .ROWS(ROWS), .BPC(BPC), .SCROLL_SHIFT(2), .ANIM_SHIFT(10), .FC_W(13)) dut (
    .pixclk(pixclk),
    .reset(reset),
    .frame_tick(frame_tick),
    .mode(mode),
    .color(color),
    .bus(bus),
    .display(display),
    .frame_done(frame_done),
    .overrun(overrun)
  );

  always #5 pixclk = ~pixclk;

  function automatic logic [23:0] rom_word(input logic [8:0] a, input logic [2:0] f);
    return {a[7:0], a[7:0] ^ 8'h5A, 4'h0, a[8], f};
  endfunction

  assign bus.img_rgb = rom_q;
  always @(posedge pixclk) rom_q <= rom_word(bus.img_addr, bus.img_frame);

  function automatic logic [23:0] expect_px(input logic [1:0] m, input logic [23:0] c, input int fc, input int a);
    int col, row, ra;
    col = a % COLS;
    row = a / COLS;
    ra = row * COLS + ((col - (fc >> 2)) & (COLS - 1));
    case (m)
      2'd0: return c;
      2'd1: return {8'(col * 8), 8'(row * 16), 8'(fc)};
      2'd2: return ((((col >> 2) ^ (row >> 2) ^ (fc >> 4)) & 1) != 0) ? c : 24'h0;
      default: return rom_word(9'(ra), 3'(fc >> 10));
    endcase
  endfunction

  function automatic int pixel_errors(input logic [1:0] m, input logic [23:0] c, input int fc);
    int n = 0;
    for (int i = 0; i < N; i++)
      if (got_addr[i] !== 9'(i) || got_rgb[i] !== expect_px(m, c, fc, i)) n++;
    return n;
  endfunction

  task automatic run_frame(input logic [1:0] m, input logic [23:0] c, input int pct, input int inj_k, input int abort_at);
    logic p_stall;
    logic [8:0] p_addr, p_ia;
    logic [23:0] p_rgb;
    for (int i = 0; i < N; i++) begin
      got_addr[i] = 'x;
      got_rgb[i] = 'x;
    end
    wr_n = 0; t_first = -1; t_last = -1; done_n = 0; done_k = -1;
    ovr_n = 0; ovr_k = -1; stall_bad = 0; disp_done = 1'bx;
    p_stall = 1'b0; p_addr = '0; p_ia = '0; p_rgb = '0;
    mode = m;
    color = c;
    frame_tick = 1'b1;
    for (int k = 1; k < 3000; k++) begin
      @(posedge pixclk); #1;
      frame_tick = (k == inj_k);
      bus.wr_ready = (int'($urandom_range(99)) < pct);
      if (k == 2) begin
        ia2 = bus.img_addr;
        if2 = bus.img_frame;
      end
      if (p_stall && (!bus.wr_valid || bus.wr_addr !== p_addr || bus.wr_rgb !== p_rgb || bus.img_addr !== p_ia))
        stall_bad++;
      if (frame_done) begin
        done_n++;
        done_k = k;
        disp_done = display;
      end
      if (overrun) begin
        ovr_n++;
        ovr_k = k;
      end
      p_stall = bus.wr_valid && !bus.wr_ready;
      p_addr = bus.wr_addr;
      p_rgb = bus.wr_rgb;
      p_ia = bus.img_addr;
      if (bus.wr_valid && bus.wr_ready) begin
        if (wr_n == 0) t_first = k;
        t_last = k;
        if (wr_n < N) begin
          got_addr[wr_n] = bus.wr_addr;
          got_rgb[wr_n] = bus.wr_rgb;
        end
        wr_n++;
        if (wr_n == abort_at) break;
      end
      if (done_n > 0 && k == done_k + 2) break;
    end
    frame_tick = 1'b0;
    bus.wr_ready = 1'b1;
    if (abort_at < 0) begin
      fc_exp++;
      disp_exp = ~disp_exp;
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (2) @(posedge pixclk);
    #1;
    tests++; if (bus.wr_valid !== 1'b0) begin fails++; $display("FAIL reset_wr_valid: got %b want 0", bus.wr_valid); end
    tests++; if (bus.wr_addr !== 9'd0) begin fails++; $display("FAIL reset_wr_addr: got %0d want 0", bus.wr_addr); end
    tests++; if (bus.wr_rgb !== 24'h0) begin fails++; $display("FAIL reset_wr_rgb: got %h want 000000", bus.wr_rgb); end
    tests++; if (display !== 1'b0) begin fails++; $display("FAIL reset_display: got %b want 0", display); end
    tests++; if (frame_done !== 1'b0) begin fails++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
    tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    tests++; if (bus.img_addr !== 9'd0) begin fails++; $display("FAIL reset_img_addr: got %0d want 0", bus.img_addr); end
    tests++; if (bus.img_frame !== 3'd0) begin fails++; $display("FAIL reset_img_frame: got %0d want 0", bus.img_frame); end
    reset = 1'b1;
    @(posedge pixclk); #1;
  endtask

  task automatic test_solid;
    int bad;
    run_frame(2'd0, 24'hFF0000, 100, -1, -1);
    bad = pixel_errors(2'd0, 24'hFF0000, 0);
    tests++; if (wr_n !== N) begin fails++; $display("FAIL solid_count: got %0d writes want %0d", wr_n, N); end
    tests++; if (t_first !== 2) begin fails++; $display("FAIL solid_first: first write at T+%0d want T+2", t_first); end
    tests++; if (t_last !== N + 1) begin fails++; $display("FAIL solid_last: last write at T+%0d want T+%0d", t_last, N + 1); end
    tests++; if (bad !== 0) begin fails++; $display("FAIL solid_pixels: %0d bad writes want 0 (pix0 addr %0d rgb %h)", bad, got_addr[0], got_rgb[0]); end
    tests++; if (done_n !== 1) begin fails++; $display("FAIL solid_done_count: got %0d pulses want 1", done_n); end
    tests++; if (done_k !== N + 2) begin fails++; $display("FAIL solid_done_time: got T+%0d want T+%0d", done_k, N + 2); end
    tests++; if (disp_done !== 1'b1) begin fails++; $display("FAIL solid_display: got %b want 1", disp_done); end
    tests++; if (ovr_n !== 0) begin fails++; $display("FAIL solid_overrun: got %0d pulses want 0", ovr_n); end
  endtask

  task automatic test_checker;
    int bad;
    run_frame(2'd2, 24'h00FF00, 100, -1, -1);
    bad = pixel_errors(2'd2, 24'h00FF00, 1);
    tests++; if (got_rgb[4] !== 24'h00FF00) begin fails++; $display("FAIL checker_col4: got %h want 00ff00", got_rgb[4]); end
    tests++; if (got_rgb[132] !== 24'h000000) begin fails++; $display("FAIL checker_col4_row4: got %h want 000000", got_rgb[132]); end
    tests++; if (bad !== 0) begin fails++; $display("FAIL checker_pixels: %0d bad writes want 0", bad); end
    tests++; if (disp_done !== 1'b0) begin fails++; $display("FAIL checker_display: got %b want 0", disp_done); end
  endtask

  task automatic test_overrun;
    int bad;
    run_frame(2'd0, 24'h0000FF, 100, 50, -1);
    bad = pixel_errors(2'd0, 24'h0000FF, 2);
    tests++; if (ovr_n !== 1) begin fails++; $display("FAIL overrun_count: got %0d pulses want 1", ovr_n); end
    tests++; if (ovr_k !== 51) begin fails++; $display("FAIL overrun_time: got T+%0d want T+51", ovr_k); end
    tests++; if (wr_n !== N || bad !== 0) begin fails++; $display("FAIL overrun_frame: %0d writes %0d bad want %0d writes 0 bad", wr_n, bad, N); end
    tests++; if (done_n !== 1 || done_k !== N + 2) begin fails++; $display("FAIL overrun_done: %0d pulses at T+%0d want 1 at T+%0d", done_n, done_k, N + 2); end
  endtask

  task automatic test_gradient;
    int bad;
    run_frame(2'd1, 24'h0, 100, -1, -1);
    bad = pixel_errors(2'd1, 24'h0, 3);
    tests++; if (got_rgb[69] !== 24'h282003) begin fails++; $display("FAIL gradient_c5_r2: got %h want 282003", got_rgb[69]); end
    tests++; if (bad !== 0) begin fails++; $display("FAIL gradient_pixels: %0d bad writes want 0", bad); end
  endtask

  task automatic test_backpressure;
    int bad;
    run_frame(2'd1, 24'h0, 50, -1, -1);
    bad = pixel_errors(2'd1, 24'h0, 4);
    tests++; if (wr_n !== N) begin fails++; $display("FAIL bp_count: got %0d writes want %0d", wr_n, N); end
    tests++; if (bad !== 0) begin fails++; $display("FAIL bp_pixels: %0d bad writes want 0", bad); end
    tests++; if (stall_bad !== 0) begin fails++; $display("FAIL bp_stall_stable: %0d unstable stall cycles want 0", stall_bad); end
    tests++; if (done_n !== 1) begin fails++; $display("FAIL bp_done: got %0d pulses want 1", done_n); end
  endtask

  task automatic test_back_to_back;
    int bad;
    for (int f = 5; f < 16; f++) begin
      run_frame(2'd0, 24'(f * 24'h010203), 100, -1, -1);
      bad = pixel_errors(2'd0, 24'(f * 24'h010203), f);
      tests++;
      if (done_n !== 1 || disp_done !== disp_exp || bad !== 0)
        begin fails++; $display("FAIL b2b_frame%0d: done %0d display %b bad %0d want 1 %b 0", f, done_n, disp_done, bad, disp_exp); end
    end
  endtask

  task automatic test_image;
    int bad;
    run_frame(2'd3, 24'h0, 50, -1, -1);
    bad = pixel_errors(2'd3, 24'h0, 16);
    tests++; if (ia2 !== 9'd29) begin fails++; $display("FAIL image_addr_c1: got %0d want 29", ia2); end
    tests++; if (if2 !== 3'd0) begin fails++; $display("FAIL image_frame: got %0d want 0", if2); end
    tests++; if (wr_n !== N || bad !== 0) begin fails++; $display("FAIL image_pixels: %0d writes %0d bad want %0d writes 0 bad", wr_n, bad, N); end
    tests++; if (stall_bad !== 0) begin fails++; $display("FAIL image_stall_stable: %0d unstable stall cycles want 0", stall_bad); end
  endtask

  task automatic test_reset_mid;
    int seen;
    seen = 0;
    run_frame(2'd0, 24'h123456, 100, -1, 100);
    reset = 1'b0;
    @(posedge pixclk); #1;
    tests++; if (bus.wr_valid !== 1'b0) begin fails++; $display("FAIL abort_wr_valid: got %b want 0", bus.wr_valid); end
    tests++; if (display !== 1'b0) begin fails++; $display("FAIL abort_display: got %b want 0", display); end
    tests++; if (bus.img_addr !== 9'd0) begin fails++; $display("FAIL abort_img_addr: got %0d want 0", bus.img_addr); end
    reset = 1'b1;
    for (int k = 0; k < 700; k++) begin
      @(posedge pixclk); #1;
      if (frame_done || bus.wr_valid) seen++;
    end
    tests++; if (seen !== 0) begin fails++; $display("FAIL abort_quiet: %0d cycles with frame_done or wr_valid want 0", seen); end
    fc_exp = 0;
    disp_exp = 1'b0;
  endtask

  task automatic test_after_reset;
    int bad;
    run_frame(2'd1, 24'h0, 100, -1, -1);
    bad = pixel_errors(2'd1, 24'h0, 0);
    tests++; if (bad !== 0) begin fails++; $display("FAIL after_reset_fc0: %0d bad writes want 0 (pix0 %h want 000000)", bad, got_rgb[0]); end
    tests++; if (disp_done !== 1'b1) begin fails++; $display("FAIL after_reset_display: got %b want 1", disp_done); end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.wr_ready = 1'b1;
    test_reset();
    test_solid();
    test_checker();
    test_overrun();
    test_gradient();
    test_backpressure();
    test_back_to_back();
    test_image();
    test_reset_mid();
    test_after_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
